// File: rtl/regbus_master_if.sv
// -----------------------------------------------------------------------------
// regbus_master_if
// Host-side byte-stream channels of the register-bus bridge.
//   in_data   [7:0]  host -> bridge command/data byte
//   in_valid         in_data valid
//   in_ready         bridge accepts in_data this cycle
//   out_data  [7:0]  bridge -> host read response byte
//   out_valid        out_data valid
//   out_ready        host accepts out_data
// Modports:
//   master : the bridge (regbus_master), which masters the register bus
//   slave  : the host side that feeds commands and drains responses
// -----------------------------------------------------------------------------
interface regbus_master_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/regbus_master.sv
// -----------------------------------------------------------------------------
// regbus_master
// Byte-stream to register-bus bridge. Parses command bytes from the host
// (CMD: bit7 = write, bits[6:0] = LEN-1; then start address; then LEN data
// bytes for a write), issues single-cycle rd/wr strobes on the shared
// address / tri-state data bus with address auto-increment, and returns read
// data to the host as a byte stream.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   hif           host byte streams (regbus_master_if.master)
//   address [7:0] register bus address (holds between commands)
//   data    [7:0] register bus data, driven only during the write strobe
//   rd            one-cycle read strobe
//   wr            one-cycle write strobe
//   busy          high whenever the FSM is not IDLE
//
// Parameters:
//   READ_LATENCY  cycles from the rd cycle to the bus sampling edge (0..7)
//   IDLE_DATA     out_data value while out_valid is low
//
// Optional feature (macro REGBUS_WRITE_ACK_EN): when defined, a write burst
// ends by returning one 8'hA5 acknowledge byte through the response stream.
// -----------------------------------------------------------------------------
module regbus_master #(
    parameter int         READ_LATENCY = 1,
    parameter logic [7:0] IDLE_DATA    = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset,
    regbus_master_if.master        hif,
    output logic [7:0]             address,
    inout  wire  [7:0]             data,
    output logic                   rd,
    output logic                   wr,
    output logic                   busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        WDATA   = 3'd2,
        WSTROBE = 3'd3,
        RSTROBE = 3'd4,
        RWAIT   = 3'd5,
        RSEND   = 3'd6
    } state_t;

    // Preload for the RWAIT counter: RWAIT lasts READ_LATENCY cycles and the
    // sample is taken when the counter reaches zero.
    localparam logic [2:0] LAT_M1 = (READ_LATENCY == 0) ? 3'd0 : 3'(READ_LATENCY - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_write;
    logic [6:0] r_count;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic [2:0] r_lat;

    logic       w_in_ready;
    logic       w_in_fire;
    logic       w_out_valid;
    logic       w_out_fire;
    logic       w_last;

    assign w_in_fire  = hif.in_valid && w_in_ready;
    assign w_out_fire = w_out_valid && hif.out_ready;
    assign w_last     = (r_count == 7'd0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and bus/host outputs
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (w_in_fire) w_next = ADDR;
            end
            ADDR: begin
                w_in_ready = 1'b1;
                if (w_in_fire) w_next = r_write ? WDATA : RSTROBE;
            end
            WDATA: begin
                w_in_ready = 1'b1;
                if (w_in_fire) w_next = WSTROBE;
            end
            WSTROBE: begin
                wr = 1'b1;
                if (w_last) begin
`ifdef REGBUS_WRITE_ACK_EN
                    w_next = RSEND;
`else
                    w_next = IDLE;
`endif
                end else begin
                    w_next = WDATA;
                end
            end
            RSTROBE: begin
                rd     = 1'b1;
                w_next = (READ_LATENCY == 0) ? RSEND : RWAIT;
            end
            RWAIT: begin
                if (r_lat == 3'd0) w_next = RSEND;
            end
            RSEND: begin
                w_out_valid = 1'b1;
                if (w_out_fire) w_next = w_last ? IDLE : RSTROBE;
            end
            default: w_next = IDLE;
        endcase
        // No byte is taken while reset is asserted.
        if (reset) w_in_ready = 1'b0;
    end

    // Command, address, count and data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write <= 1'b0;
            r_count <= 7'd0;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_rdata <= IDLE_DATA;
            r_lat   <= 3'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_in_fire) begin
                        r_write <= hif.in_data[7];
                        r_count <= hif.in_data[6:0];
                    end
                end
                ADDR: begin
                    if (w_in_fire) r_addr <= hif.in_data;
                end
                WDATA: begin
                    if (w_in_fire) r_wdata <= hif.in_data;
                end
                WSTROBE: begin
                    if (!w_last) begin
                        r_addr  <= r_addr + 8'd1;
                        r_count <= r_count - 7'd1;
                    end
`ifdef REGBUS_WRITE_ACK_EN
                    else begin
                        r_rdata <= 8'hA5;
                    end
`endif
                end
                RSTROBE: begin
                    if (READ_LATENCY == 0) r_rdata <= data;
                    else                   r_lat   <= LAT_M1;
                end
                RWAIT: begin
                    if (r_lat == 3'd0) r_rdata <= data;
                    else               r_lat   <= r_lat - 3'd1;
                end
                RSEND: begin
                    if (w_out_fire && !w_last) begin
                        r_addr  <= r_addr + 8'd1;
                        r_count <= r_count - 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hif.in_ready  = w_in_ready;
    assign hif.out_valid = w_out_valid;
    assign hif.out_data  = w_out_valid ? r_rdata : IDLE_DATA;
    assign address       = r_addr;
    assign busy          = (r_state != IDLE);
    // The bridge only drives the shared data bus during its write strobe.
    assign data          = (r_state == WSTROBE) ? r_wdata : 8'hzz;

endmodule
